// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: memory port controller between the multi-cycle cpu core and
// the shared single-port memory. Serves one fetch or data access at a time,
// stretching each over WAIT_CYCLES+1 memory cycles, then acks for one cycle.
// Data requests win over fetches when both are pending in IDLE.
// Optional feature macro: MEM_INST_COUNT_EN (completed-fetch counter num_inst;
// when undefined, num_inst is tied to zero).
module mem_port_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] rdata,
    output logic        readM,
    output logic        writeM,
    output logic [15:0] address,
    inout  wire  [15:0] data,
    output logic [15:0] num_inst
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic        r_src_fetch;
    logic [15:0] r_wdata;
    logic [15:0] r_address;
    logic        r_readM;
    logic        r_writeM;
    logic        r_if_ack;
    logic        r_d_ack;
    logic [15:0] r_rdata;
    logic        w_last;
    logic        w_access_next;
    logic [15:0] w_req_addr;

    // Final strobe cycle of the current access
    assign w_last        = (r_state == READ || r_state == WRITE) && (r_cnt == '0);
    assign w_access_next = (w_state_next == READ) || (w_state_next == WRITE);
    // Address of whichever request wins arbitration in IDLE
    assign w_req_addr    = d_req ? d_addr : if_addr;

    // Next-state logic: arbitration in IDLE, access length via down-counter
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (d_req) begin
                    w_state_next = d_we ? WRITE : READ;
                end else if (if_req) begin
                    w_state_next = READ;
                end
            end
            READ, WRITE: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wait counter: loaded while idle so it is valid on entry to READ/WRITE
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= LP_WAIT;
        end else if ((r_state == READ || r_state == WRITE) && r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture: inputs are only sampled in IDLE
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_src_fetch <= 1'b0;
            r_wdata     <= '0;
        end else if (r_state == IDLE) begin
            if (d_req) begin
                r_src_fetch <= 1'b0;
                r_wdata     <= d_wdata;
            end else if (if_req) begin
                r_src_fetch <= 1'b1;
            end
        end
    end

    // Registered memory-side outputs, decoded from the next state so they are
    // glitch-free and the address register doubles as the latched address
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_readM   <= 1'b0;
            r_writeM  <= 1'b0;
            r_address <= '0;
        end else begin
            r_readM  <= (w_state_next == READ);
            r_writeM <= (w_state_next == WRITE);
            if (w_access_next) begin
                r_address <= (r_state == IDLE) ? w_req_addr : r_address;
            end else begin
                r_address <= '0;
            end
        end
    end

    // One-cycle acknowledge in DONE, routed by the latched source
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
        end else begin
            r_if_ack <= (w_state_next == DONE) && r_src_fetch;
            r_d_ack  <= (w_state_next == DONE) && !r_src_fetch;
        end
    end

    // Read data capture on the closing edge of the last read cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rdata <= '0;
        end else if (w_last && r_state == READ) begin
            r_rdata <= data;
        end
    end

`ifdef MEM_INST_COUNT_EN
    logic [15:0] r_num_inst;

    // Completed-fetch counter; bumps together with the ack so the count is
    // already updated while if_ack is high. Wraps naturally at 16 bits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_num_inst <= '0;
        end else if (w_last && r_state == READ && r_src_fetch) begin
            r_num_inst <= r_num_inst + 16'd1;
        end
    end

    assign num_inst = r_num_inst;
`else
    assign num_inst = '0;
`endif

    assign readM   = r_readM;
    assign writeM  = r_writeM;
    assign address = r_address;
    assign if_ack  = r_if_ack;
    assign d_ack   = r_d_ack;
    assign rdata   = r_rdata;
    assign data    = r_writeM ? r_wdata : 16'hzzzz;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Testbench for mem_port_ctrl: directed accesses, scoreboard of expected acks
// checked by an independent monitor, plus inline strobe/bus timing checks.
module tb_mem_port_ctrl;

    localparam int unsigned W = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, readM, writeM;
    logic [15:0] rdata, address, num_inst;
    wire  [15:0] data_bus;

    // Second instance with zero wait cycles
    logic        if_req0;
    logic [15:0] if_addr0;
    logic        if_ack0, d_ack0, readM0, writeM0;
    logic [15:0] rdata0, address0, num_inst0;
    wire  [15:0] data_bus0;

    logic [15:0] mem [0:255];

    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_tot  = 0;
    logic [15:0] exp_ninst = 16'h0;
    logic [15:0] last_rd   = 16'h0;

    typedef struct {
        bit          fetch;
        logic [15:0] rd;
        logic [15:0] ninst;
        int unsigned cyc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_ctrl #(.WAIT_CYCLES(W)) dut (
        .Clk(clk), .Reset(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .readM(readM), .writeM(writeM), .address(address),
        .data(data_bus), .num_inst(num_inst)
    );

    mem_port_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .Clk(clk), .Reset(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0), .d_wdata(16'h0), .d_ack(d_ack0),
        .rdata(rdata0), .readM(readM0), .writeM(writeM0), .address(address0),
        .data(data_bus0), .num_inst(num_inst0)
    );

    // Memory model: combinational read, write on clock edge
    assign data_bus  = readM  ? mem[address[7:0]]  : 16'hzzzz;
    assign data_bus0 = readM0 ? mem[address0[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (writeM) mem[address[7:0]] <= data_bus;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_tot++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endfunction

    // Ack monitor: pops the scoreboard whenever the DUT acknowledges
    always @(negedge clk) begin
        if (if_ack === 1'b1 || d_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {30'h0, if_ack, d_ack}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_src", {30'h0, if_ack, d_ack}, e.fetch ? 32'h2 : 32'h1);
                check("ack_cycle", cyc, e.cyc);
                check("ack_rdata", rdata, e.rd);
                check("ack_num_inst", num_inst, e.ninst);
            end
        end
    end

    // One access on the W instance with per-cycle strobe/address/bus checks
    task automatic do_access(input bit fetch, input bit we, input logic [15:0] addr,
                             input logic [15:0] wd, input logic [15:0] exp_rd);
        int unsigned t0;
        exp_t e;
        @(posedge clk); #1;
        if (fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end
        t0 = cyc;
`ifdef MEM_INST_COUNT_EN
        if (fetch) exp_ninst = exp_ninst + 16'd1;
`endif
        if (!we || fetch) last_rd = exp_rd;
        e.fetch = fetch; e.rd = last_rd; e.ninst = exp_ninst; e.cyc = t0 + W + 2;
        exp_q.push_back(e);
        for (int k = 1; k <= int'(W) + 2; k++) begin
            @(posedge clk); @(negedge clk);
            if (k <= int'(W) + 1) begin
                check("readM_active", readM, (fetch || !we) ? 1 : 0);
                check("writeM_active", writeM, (fetch || !we) ? 0 : 1);
                check("address_active", address, addr);
                if (!fetch && we) check("bus_write_data", data_bus, wd);
            end else begin
                check("strobes_after", {readM, writeM}, 0);
                check("address_after", address, 0);
                if (!fetch && we) check("bus_released", data_bus !== wd, 1);
                if_req = 1'b0; d_req = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        mem[8'h10] = 16'h4A05;
        mem[8'h30] = 16'h1234;
        mem[8'h00] = 16'h7C01;
        rst = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        if_req0 = 0; if_addr0 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", {readM, writeM, if_ack, d_ack}, 0);
        check("reset_address", address, 0);
        check("reset_rdata", rdata, 0);
        check("reset_num_inst", num_inst, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Fetch from 0x0010
        do_access(1, 0, 16'h0010, 16'h0, 16'h4A05);
        // Store 0xBEEF to 0x0020, then load it back
        do_access(0, 1, 16'h0020, 16'hBEEF, 16'h0);
        do_access(0, 0, 16'h0020, 16'h0, 16'hBEEF);
        // A few more fetches from a small table
        do_access(1, 0, 16'h0005, 16'h0, 16'h000F);
        do_access(1, 0, 16'h0040, 16'h0, 16'h00C0);
        // Store then fetch from same location (fetch sees stored word)
        do_access(0, 1, 16'h0041, 16'h55AA, 16'h0);
        do_access(1, 0, 16'h0041, 16'h0, 16'h55AA);

        // Simultaneous data load and fetch: data wins, fetch served next
        begin
            int unsigned t0;
            exp_t e;
            @(posedge clk); #1;
            d_req = 1; d_we = 0; d_addr = 16'h0030; if_req = 1; if_addr = 16'h0010;
            t0 = cyc;
            last_rd = 16'h1234;
            e.fetch = 0; e.rd = 16'h1234; e.ninst = exp_ninst; e.cyc = t0 + 3;
            exp_q.push_back(e);
`ifdef MEM_INST_COUNT_EN
            exp_ninst = exp_ninst + 16'd1;
`endif
            last_rd = 16'h4A05;
            e.fetch = 1; e.rd = 16'h4A05; e.ninst = exp_ninst; e.cyc = t0 + 7;
            exp_q.push_back(e);
            for (int k = 1; k <= 7; k++) begin
                @(posedge clk); @(negedge clk);
                if (k == 1) begin
                    check("prio_data_first", readM, 1);
                    check("prio_data_addr", address, 16'h0030);
                end
                if (k == 3) d_req = 0;
                if (k == 4) check("prio_gap", readM, 0);
                if (k == 5) begin
                    check("prio_fetch_strobe", readM, 1);
                    check("prio_fetch_addr", address, 16'h0010);
                end
                if (k == 7) if_req = 0;
            end
        end

`ifdef MEM_INST_COUNT_EN
        // Counter wrap: preload all-ones, one more fetch wraps to zero
        @(posedge clk); #1;
        force dut.r_num_inst = 16'hFFFF;
        #1 release dut.r_num_inst;
        exp_ninst = 16'hFFFF;
        do_access(1, 0, 16'h0010, 16'h0, 16'h4A05);
        check("num_inst_wrapped", num_inst, 16'h0000);
`else
        check("num_inst_tied", num_inst, 16'h0000);
`endif

        // Reset in cycle 2 of a write aborts it without an ack
        begin
            @(posedge clk); #1;
            d_req = 1; d_we = 1; d_addr = 16'h0050; d_wdata = 16'hBEEF;
            @(posedge clk); @(negedge clk);
            check("rst_write_started", writeM, 1);
            @(posedge clk); #1 rst = 1; d_req = 0;
            @(posedge clk); @(negedge clk);
            check("rst_writeM_low", writeM, 0);
            check("rst_bus_released", data_bus !== 16'hBEEF, 1);
            check("rst_no_ack", d_ack, 0);
            check("rst_address", address, 0);
            check("rst_rdata", rdata, 0);
            @(posedge clk); #1 rst = 0;
            exp_ninst = 16'h0; last_rd = 16'h0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("rst_still_no_ack", {if_ack, d_ack}, 0);
        end

        // Zero wait cycles: single-cycle strobe, ack in cycle 2
        begin
            @(posedge clk); #1;
            if_req0 = 1; if_addr0 = 16'h0000;
            @(posedge clk); @(negedge clk);
            check("w0_readM_c1", readM0, 1);
            check("w0_ack_c1", if_ack0, 0);
            @(posedge clk); @(negedge clk);
            check("w0_readM_c2", readM0, 0);
            check("w0_ack_c2", if_ack0, 1);
            check("w0_rdata", rdata0, 16'h7C01);
`ifdef MEM_INST_COUNT_EN
            check("w0_num_inst", num_inst0, 16'h0001);
`else
            check("w0_num_inst", num_inst0, 16'h0000);
`endif
            if_req0 = 0;
            @(posedge clk); @(negedge clk);
            check("w0_ack_single", if_ack0, 0);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pending_acks", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
